// File: rtl/scope_pkg.sv
// Shared definitions for the oscilloscope trace renderer.
//   - default display window and grid geometry
//   - overlay colours for the grid and the window border
//   - the per-channel sample type and the packed VGA pixel record used by
//     the renderer's timing delay line
package scope_pkg;

  localparam int DEF_SAMPLE_W  = 12;
  localparam int DEF_H_ORIGIN  = 16;
  localparam int DEF_V_BOTTOM  = 560;
  localparam int DEF_WIDTH     = 512;
  localparam int DEF_HEIGHT    = 512;
  localparam int DEF_GRID_STEP = 64;

  localparam logic [11:0] GRID_COLOR   = 12'h444;
  localparam logic [11:0] BORDER_COLOR = 12'hfff;

  typedef logic [11:0]             rgb_t;
  typedef logic [DEF_SAMPLE_W-1:0] sample_t;

  // One pixel's worth of VGA timing plus colour.
  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    rgb_t        rgb;
  } vga_t;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream: timing counters, sync, blanking and 12-bit colour.
//   modport in  : consumer side (all fields are inputs)
//   modport out : producer side (all fields are outputs)
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_trace_hit.sv
// Per-channel trace hit detector.
//   clk, rst            : clock, synchronous active-high reset
//   sample              : RAM read data for this channel
//   scale_shift         : right shift applied to the sample
//   y_offset, _neg      : vertical shift in pixels and its direction
//   enable              : channel draw enable
//   first_px            : current pixel is the first window pixel of a line
//   idx_changed         : sample index differs from the previous pixel's
//   row                 : plot row of the current pixel (0 = bottom)
//   hit                 : row lies on the segment from the previous sample
//                         to the current one (combinational)
module draw_trace_hit
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int ROW_W    = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [3:0]          scale_shift,
  input  logic [10:0]         y_offset,
  input  logic                y_offset_neg,
  input  logic                enable,
  input  logic                first_px,
  input  logic                idx_changed,
  input  logic [ROW_W-1:0]    row,
  output logic                hit
);

  localparam int Y_W = $clog2(HEIGHT);
  // Two bits beyond the wider operand: a sign bit plus carry room, so the
  // largest sample plus the largest offset saturates instead of wrapping.
  localparam int SUM_W = ((SAMPLE_W > 11) ? SAMPLE_W : 11) + 2;
  localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'(HEIGHT - 1);

  logic [SAMPLE_W-1:0]     shifted;
  logic signed [SUM_W-1:0] y_sum;
  logic [Y_W-1:0]          y;
  logic [Y_W-1:0]          last_y;   // y of the previous pixel
  logic [Y_W-1:0]          prev_y;   // y of the previous distinct sample
  logic [Y_W-1:0]          seg_y;
  logic [Y_W-1:0]          lo;
  logic [Y_W-1:0]          hi;

  always_comb begin
    shifted = sample >> scale_shift;
    if (y_offset_neg) begin
      y_sum = $signed(SUM_W'(shifted)) - $signed(SUM_W'(y_offset));
    end else begin
      y_sum = $signed(SUM_W'(shifted)) + $signed(SUM_W'(y_offset));
    end

    if (y_sum[SUM_W-1]) begin
      y = '0;
    end else if (y_sum > Y_MAX) begin
      y = Y_W'(HEIGHT - 1);
    end else begin
      y = y_sum[Y_W-1:0];
    end

    // Segment start: collapses to a point at the line start, moves to the
    // last pixel's y whenever the sample index advances, otherwise holds.
    if (first_px) begin
      seg_y = y;
    end else if (idx_changed) begin
      seg_y = last_y;
    end else begin
      seg_y = prev_y;
    end

    lo  = (seg_y < y) ? seg_y : y;
    hi  = (seg_y < y) ? y : seg_y;
    hit = enable && (row >= ROW_W'(lo)) && (row <= ROW_W'(hi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_y <= '0;
      last_y <= '0;
    end else begin
      prev_y <= seg_y;
      last_y <= y;
    end
  end

endmodule

// File: rtl/draw_scope_traces.sv
// Multi-channel oscilloscope trace renderer overlaid on a VGA stream.
//   clk, rst                  : clock, synchronous active-high reset
//   in                        : incoming VGA timing and colour
//   out                       : same timing delayed 3 cycles, composited rgb
//   sample_addr               : shared read address for all channel RAMs
//   sample_data               : RAM read data, one cycle after sample_addr
//   x_offset, x_offset_neg    : horizontal pan in samples and direction
//   y_offset, y_offset_neg    : vertical shift in pixels and direction
//   scale_shift               : sample right shift
//   h_zoom                    : pixels per sample = 1 << h_zoom
//   ch_enable, ch_color       : per-channel draw enable and colour
// Controls are captured on the rising edge of in.vblnk and only the captured
// copies drive rendering, so a frame is always drawn with one setting.
// Pipeline: cycle t pixel -> sample_addr at t+1 -> sample_data at t+2 ->
// hit/composite registered into out at t+3.
module draw_scope_traces
  import scope_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int H_ORIGIN  = DEF_H_ORIGIN,
  parameter int V_BOTTOM  = DEF_V_BOTTOM,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int GRID_STEP = DEF_GRID_STEP
) (
  input  logic                         clk,
  input  logic                         rst,
  vga_if.in                            in,
  vga_if.out                           out,
  output logic [ADDR_W-1:0]            sample_addr,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
  input  logic [ADDR_W-1:0]            x_offset,
  input  logic                         x_offset_neg,
  input  logic [10:0]                  y_offset,
  input  logic                         y_offset_neg,
  input  logic [3:0]                   scale_shift,
  input  logic [1:0]                   h_zoom,
  input  logic [CHANNELS-1:0]          ch_enable,
  input  logic [CHANNELS*12-1:0]       ch_color
);

  localparam logic [10:0] H_LO      = 11'(H_ORIGIN);
  localparam logic [10:0] H_HI      = 11'(H_ORIGIN + WIDTH);
  localparam logic [10:0] V_LO      = 11'(V_BOTTOM - HEIGHT);
  localparam logic [10:0] V_HI      = 11'(V_BOTTOM);
  localparam logic [10:0] GRID_MASK = 11'(GRID_STEP - 1);

  // Frame latch
  logic                   vblnk_q;
  logic                   frame_latch;
  logic [ADDR_W-1:0]      sh_x_offset;
  logic                   sh_x_neg;
  logic [10:0]            sh_y_offset;
  logic                   sh_y_neg;
  logic [3:0]             sh_scale;
  logic [1:0]             sh_zoom;
  logic [CHANNELS-1:0]    sh_enable;
  logic [CHANNELS*12-1:0] sh_color;

  assign frame_latch = in.vblnk & ~vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q     <= 1'b0;
      sh_x_offset <= '0;
      sh_x_neg    <= 1'b0;
      sh_y_offset <= '0;
      sh_y_neg    <= 1'b0;
      sh_scale    <= '0;
      sh_zoom     <= '0;
      sh_enable   <= '0;
      sh_color    <= '0;
    end else begin
      vblnk_q <= in.vblnk;
      if (frame_latch) begin
        sh_x_offset <= x_offset;
        sh_x_neg    <= x_offset_neg;
        sh_y_offset <= y_offset;
        sh_y_neg    <= y_offset_neg;
        sh_scale    <= scale_shift;
        sh_zoom     <= h_zoom;
        sh_enable   <= ch_enable;
        sh_color    <= ch_color;
      end
    end
  end

  // S0: address generation; the index wraps naturally at ADDR_W bits.
  logic [10:0]       x0;
  logic [10:0]       xz;
  logic [ADDR_W-1:0] idx0;
  vga_t              px0;

  always_comb begin
    x0   = in.hcount - H_LO;
    xz   = x0 >> sh_zoom;
    idx0 = sh_x_neg ? (xz[ADDR_W-1:0] - sh_x_offset)
                    : (xz[ADDR_W-1:0] + sh_x_offset);
    px0  = '{vcount: in.vcount, vsync: in.vsync, vblnk: in.vblnk,
             hcount: in.hcount, hsync: in.hsync, hblnk: in.hblnk,
             rgb: in.rgb};
  end

  // Timing delay line and index tracking
  vga_t              d1;
  vga_t              d2;
  logic [ADDR_W-1:0] idx_d2;
  logic [ADDR_W-1:0] last_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1          <= '0;
      d2          <= '0;
      sample_addr <= '0;
      idx_d2      <= '0;
      last_idx    <= '0;
    end else begin
      d1          <= px0;
      d2          <= d1;
      sample_addr <= idx0;
      idx_d2      <= sample_addr;
      last_idx    <= idx_d2;
    end
  end

  // S2: window, grid, border and per-channel hits
  logic [10:0]         row2;
  logic [10:0]         x2;
  logic                win;
  logic                grid;
  logic                border;
  logic                first_px;
  logic                idx_changed;
  logic [CHANNELS-1:0] raw_hit;

  always_comb begin
    row2        = V_HI - d2.vcount;
    x2          = d2.hcount - H_LO;
    win         = (d2.hcount >= H_LO) && (d2.hcount <= H_HI) &&
                  (d2.vcount >= V_LO) && (d2.vcount <= V_HI);
    grid        = win && (((x2 & GRID_MASK) == '0) || ((row2 & GRID_MASK) == '0));
    border      = win && ((d2.hcount == H_LO) || (d2.hcount == H_HI) ||
                          (d2.vcount == V_LO) || (d2.vcount == V_HI));
    first_px    = (d2.hcount == H_LO);
    idx_changed = (idx_d2 != last_idx);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    draw_trace_hit #(
      .SAMPLE_W (SAMPLE_W),
      .HEIGHT   (HEIGHT),
      .ROW_W    (11)
    ) u_hit (
      .clk          (clk),
      .rst          (rst),
      .sample       (sample_data[c*SAMPLE_W +: SAMPLE_W]),
      .scale_shift  (sh_scale),
      .y_offset     (sh_y_offset),
      .y_offset_neg (sh_y_neg),
      .enable       (sh_enable[c]),
      .first_px     (first_px),
      .idx_changed  (idx_changed),
      .row          (row2),
      .hit          (raw_hit[c])
    );
  end

  // Priority mux: lowest-numbered channel is applied last so it wins.
  rgb_t rgb_mux;

  always_comb begin
    rgb_mux = d2.rgb;
    if (grid) rgb_mux = GRID_COLOR;
    if (border) rgb_mux = BORDER_COLOR;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (raw_hit[c] && win) rgb_mux = sh_color[c*12 +: 12];
    end
    if (d2.hblnk || d2.vblnk) rgb_mux = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= d2.vcount;
      out.vsync  <= d2.vsync;
      out.vblnk  <= d2.vblnk;
      out.hcount <= d2.hcount;
      out.hsync  <= d2.hsync;
      out.hblnk  <= d2.hblnk;
      out.rgb    <= rgb_mux;
    end
  end

endmodule

// File: tb/tb_draw_scope_traces.sv
// Directed bench for draw_scope_traces with a synchronous-read sample RAM
// model and hand-computed expected pixels.
module tb_draw_scope_traces;
  import scope_pkg::*;

  localparam logic [11:0] BG = 12'h123;
  localparam logic [11:0] C0 = 12'hf00;
  localparam logic [11:0] C1 = 12'h0f0;

  logic        clk;
  logic        rst;
  logic [7:0]  sample_addr;
  logic [23:0] sample_data;
  logic [7:0]  x_offset;
  logic        x_offset_neg;
  logic [10:0] y_offset;
  logic        y_offset_neg;
  logic [3:0]  scale_shift;
  logic [1:0]  h_zoom;
  logic [1:0]  ch_enable;
  logic [23:0] ch_color;

  vga_if vin();
  vga_if vout();

  int errors = 0;
  int checks = 0;

  int      ram_mode;
  sample_t ram_const;

  logic [11:0] cap_rgb  [0:2047];
  logic [10:0] cap_h    [0:2047];
  logic [10:0] cap_v    [0:2047];
  logic        cap_hb   [0:2047];
  logic [7:0]  cap_addr [0:2047];

  draw_scope_traces dut (
    .clk          (clk),
    .rst          (rst),
    .in           (vin),
    .out          (vout),
    .sample_addr  (sample_addr),
    .sample_data  (sample_data),
    .x_offset     (x_offset),
    .x_offset_neg (x_offset_neg),
    .y_offset     (y_offset),
    .y_offset_neg (y_offset_neg),
    .scale_shift  (scale_shift),
    .h_zoom       (h_zoom),
    .ch_enable    (ch_enable),
    .ch_color     (ch_color)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample RAM: synchronous read, data one cycle after the address.
  always @(posedge clk) begin
    if (ram_mode == 0) begin
      sample_data <= {ram_const, ram_const};
    end else begin
      sample_data <= {12'd0, (sample_addr < 8'd10) ? 12'd0 : 12'd400};
    end
  end

  // Drivers
  task automatic drive_px(input int h, input logic [10:0] v, input logic hb, input logic vb);
    vin.hcount = 11'(h);
    vin.vcount = v;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = BG;
  endtask

  task automatic latch_controls();
    drive_px(0, 11'd600, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    vin.vblnk = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives hcount h0..h1 on row v and records what comes out for each pixel.
  task automatic scan_line(input logic [10:0] v, input int h0, input int h1, input logic hb);
    for (int i = 0; i <= h1 - h0 + 2; i++) begin
      drive_px(h0 + i, v, hb, 1'b0);
      @(posedge clk); #1;
      cap_addr[h0 + i] = sample_addr;
      if (i >= 2) begin
        cap_rgb[h0 + i - 2] = vout.rgb;
        cap_h[h0 + i - 2]   = vout.hcount;
        cap_v[h0 + i - 2]   = vout.vcount;
        cap_hb[h0 + i - 2]  = vout.hblnk;
      end
    end
  endtask

  task automatic set_controls(input logic [11:0] cst, input logic [3:0] sh, input logic [1:0] zm,
                              input logic [10:0] yo, input logic yneg, input logic [1:0] en);
    ram_mode     = 0;
    ram_const    = cst;
    scale_shift  = sh;
    h_zoom       = zm;
    x_offset     = 8'd0;
    x_offset_neg = 1'b0;
    y_offset     = yo;
    y_offset_neg = yneg;
    ch_enable    = en;
    ch_color     = {C1, C0};
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    vin.hcount = 11'd100; vin.vcount = 11'd304; vin.hsync = 1'b1; vin.vsync = 1'b1;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = BG;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (vout.rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", vout.rgb); end
    checks++; if (vout.hcount !== 11'd0) begin errors++; $display("FAIL reset_hcount: got %0d want 0", vout.hcount); end
    checks++; if (vout.vcount !== 11'd0) begin errors++; $display("FAIL reset_vcount: got %0d want 0", vout.vcount); end
    checks++; if ({vout.hsync, vout.vsync, vout.hblnk, vout.vblnk} !== 4'b0000) begin
      errors++; $display("FAIL reset_sync: got %b want 0000", {vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}); end
    checks++; if (sample_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", sample_addr); end
    rst = 1'b0;
    // Controls presented but never latched: nothing is drawn.
    set_controls(12'd1024, 4'd2, 2'd1, 11'd0, 1'b0, 2'b01);
    scan_line(11'd304, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== GRID_COLOR) begin errors++; $display("FAIL reset_no_trace: got %h want 444", cap_rgb[100]); end
    scan_line(11'd49, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== BG) begin errors++; $display("FAIL reset_no_trace_top: got %h want %h", cap_rgb[100], BG); end
  endtask

  task automatic test_flat();
    int bad;
    int first_bad;
    set_controls(12'd1024, 4'd2, 2'd1, 11'd0, 1'b0, 2'b01);
    latch_controls();
    scan_line(11'd304, 8, 540, 1'b0);
    bad = 0; first_bad = -1;
    for (int h = 16; h <= 528; h++) begin
      if (cap_rgb[h] !== C0) begin bad++; if (first_bad < 0) first_bad = h; end
    end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL flat_trace: %0d pixels wrong, first hcount=%0d got %h want f00", bad, first_bad, cap_rgb[(first_bad < 0) ? 0 : first_bad]); end
    checks++; if (cap_rgb[15] !== BG) begin errors++; $display("FAIL flat_left_outside: got %h want %h", cap_rgb[15], BG); end
    checks++; if (cap_rgb[529] !== BG) begin errors++; $display("FAIL flat_right_outside: got %h want %h", cap_rgb[529], BG); end
    checks++; if (cap_h[200] !== 11'd200) begin errors++; $display("FAIL latency_hcount: got %0d want 200", cap_h[200]); end
    checks++; if (cap_v[200] !== 11'd304) begin errors++; $display("FAIL latency_vcount: got %0d want 304", cap_v[200]); end
    scan_line(11'd305, 60, 110, 1'b0);
    checks++; if (cap_rgb[100] !== BG) begin errors++; $display("FAIL flat_off_trace: got %h want %h", cap_rgb[100], BG); end
    checks++; if (cap_rgb[80] !== GRID_COLOR) begin errors++; $display("FAIL grid_column: got %h want 444", cap_rgb[80]); end
    scan_line(11'd304, 90, 110, 1'b1);
    checks++; if (cap_rgb[100] !== 12'h000) begin errors++; $display("FAIL hblank_rgb: got %h want 000", cap_rgb[100]); end
    checks++; if (cap_hb[100] !== 1'b1) begin errors++; $display("FAIL hblank_delay: got %b want 1", cap_hb[100]); end
  endtask

  task automatic test_segment();
    set_controls(12'd0, 4'd0, 2'd0, 11'd0, 1'b0, 2'b01);
    ram_mode = 1;
    latch_controls();
    scan_line(11'd360, 10, 40, 1'b0);
    checks++; if (cap_rgb[26] !== C0) begin errors++; $display("FAIL seg_mid: got %h want f00", cap_rgb[26]); end
    checks++; if (cap_rgb[25] !== BG) begin errors++; $display("FAIL seg_before: got %h want %h", cap_rgb[25], BG); end
    checks++; if (cap_rgb[27] !== BG) begin errors++; $display("FAIL seg_after: got %h want %h", cap_rgb[27], BG); end
    scan_line(11'd160, 10, 40, 1'b0);
    checks++; if (cap_rgb[26] !== C0) begin errors++; $display("FAIL seg_top: got %h want f00", cap_rgb[26]); end
    checks++; if (cap_rgb[30] !== C0) begin errors++; $display("FAIL seg_high_level: got %h want f00", cap_rgb[30]); end
    checks++; if (cap_rgb[25] !== BG) begin errors++; $display("FAIL seg_top_before: got %h want %h", cap_rgb[25], BG); end
    scan_line(11'd159, 10, 40, 1'b0);
    checks++; if (cap_rgb[26] !== BG) begin errors++; $display("FAIL seg_above: got %h want %h", cap_rgb[26], BG); end
    scan_line(11'd560, 10, 40, 1'b0);
    checks++; if (cap_rgb[20] !== C0) begin errors++; $display("FAIL seg_bottom: got %h want f00", cap_rgb[20]); end
  endtask

  task automatic test_wrap();
    set_controls(12'd0, 4'd0, 2'd0, 11'd0, 1'b0, 2'b01);
    x_offset = 8'd250;
    latch_controls();
    scan_line(11'd300, 14, 30, 1'b0);
    checks++; if (cap_addr[16] !== 8'd250) begin errors++; $display("FAIL wrap_addr16: got %0d want 250", cap_addr[16]); end
    checks++; if (cap_addr[21] !== 8'd255) begin errors++; $display("FAIL wrap_addr21: got %0d want 255", cap_addr[21]); end
    checks++; if (cap_addr[22] !== 8'd0) begin errors++; $display("FAIL wrap_addr22: got %0d want 0", cap_addr[22]); end
    checks++; if (cap_addr[26] !== 8'd4) begin errors++; $display("FAIL wrap_addr26: got %0d want 4", cap_addr[26]); end
    x_offset = 8'd5; x_offset_neg = 1'b1;
    latch_controls();
    scan_line(11'd300, 14, 30, 1'b0);
    checks++; if (cap_addr[16] !== 8'd251) begin errors++; $display("FAIL wrap_neg16: got %0d want 251", cap_addr[16]); end
    checks++; if (cap_addr[25] !== 8'd4) begin errors++; $display("FAIL wrap_neg25: got %0d want 4", cap_addr[25]); end
    x_offset = 8'd0; x_offset_neg = 1'b0; h_zoom = 2'd2;
    latch_controls();
    scan_line(11'd300, 14, 40, 1'b0);
    checks++; if (cap_addr[29] !== 8'd3) begin errors++; $display("FAIL zoom_addr29: got %0d want 3", cap_addr[29]); end
  endtask

  task automatic test_saturate();
    set_controls(12'd4095, 4'd0, 2'd0, 11'd100, 1'b0, 2'b01);
    latch_controls();
    scan_line(11'd49, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== C0) begin errors++; $display("FAIL sat_high: got %h want f00", cap_rgb[100]); end
    scan_line(11'd48, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== BORDER_COLOR) begin errors++; $display("FAIL sat_top_border: got %h want fff", cap_rgb[100]); end
    scan_line(11'd560, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== BORDER_COLOR) begin errors++; $display("FAIL sat_no_wrap: got %h want fff", cap_rgb[100]); end
    set_controls(12'd50, 4'd0, 2'd0, 11'd100, 1'b1, 2'b01);
    latch_controls();
    scan_line(11'd560, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== C0) begin errors++; $display("FAIL sat_low: got %h want f00", cap_rgb[100]); end
    scan_line(11'd559, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== BG) begin errors++; $display("FAIL sat_low_above: got %h want %h", cap_rgb[100], BG); end
    scan_line(11'd561, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== BG) begin errors++; $display("FAIL below_window: got %h want %h", cap_rgb[100], BG); end
  endtask

  task automatic test_frame_latch();
    set_controls(12'd1024, 4'd2, 2'd0, 11'd0, 1'b0, 2'b01);
    latch_controls();
    scale_shift = 4'd3;
    scan_line(11'd304, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== C0) begin errors++; $display("FAIL latch_old_kept: got %h want f00", cap_rgb[100]); end
    scan_line(11'd432, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== GRID_COLOR) begin errors++; $display("FAIL latch_new_absent: got %h want 444", cap_rgb[100]); end
    latch_controls();
    scan_line(11'd432, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== C0) begin errors++; $display("FAIL latch_new_drawn: got %h want f00", cap_rgb[100]); end
    scan_line(11'd304, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== GRID_COLOR) begin errors++; $display("FAIL latch_old_gone: got %h want 444", cap_rgb[100]); end
  endtask

  task automatic test_priority_and_reset();
    set_controls(12'd1024, 4'd2, 2'd0, 11'd0, 1'b0, 2'b11);
    latch_controls();
    scan_line(11'd304, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== C0) begin errors++; $display("FAIL prio_ch0: got %h want f00", cap_rgb[100]); end
    ch_enable = 2'b10;
    latch_controls();
    scan_line(11'd304, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== C1) begin errors++; $display("FAIL prio_ch1_only: got %h want 0f0", cap_rgb[100]); end
    ch_enable = 2'b11;
    latch_controls();
    for (int h = 90; h < 100; h++) begin
      drive_px(h, 11'd304, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive_px(100, 11'd304, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (vout.rgb !== 12'h000) begin errors++; $display("FAIL midline_rgb: got %h want 000", vout.rgb); end
    checks++; if (vout.hcount !== 11'd0) begin errors++; $display("FAIL midline_hcount: got %0d want 0", vout.hcount); end
    checks++; if (vout.vcount !== 11'd0) begin errors++; $display("FAIL midline_vcount: got %0d want 0", vout.vcount); end
    checks++; if (sample_addr !== 8'd0) begin errors++; $display("FAIL midline_addr: got %0d want 0", sample_addr); end
    rst = 1'b0;
    scan_line(11'd304, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== GRID_COLOR) begin errors++; $display("FAIL after_rst_no_trace: got %h want 444", cap_rgb[100]); end
    latch_controls();
    scan_line(11'd304, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== C0) begin errors++; $display("FAIL after_latch_trace: got %h want f00", cap_rgb[100]); end
    // vblnk rises in the same cycle that rst is asserted: reset wins.
    drive_px(0, 11'd600, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vin.vblnk = 1'b0;
    @(posedge clk); #1;
    scan_line(11'd304, 90, 110, 1'b0);
    checks++; if (cap_rgb[100] !== GRID_COLOR) begin errors++; $display("FAIL rst_beats_vblnk: got %h want 444", cap_rgb[100]); end
  endtask

  initial begin
    ram_mode = 0;
    ram_const = 12'd0;
    set_controls(12'd0, 4'd0, 2'd0, 11'd0, 1'b0, 2'b00);
    drive_px(0, 11'd0, 1'b0, 1'b0);
    rst = 1'b1;
    test_reset();
    test_flat();
    test_segment();
    test_wrap();
    test_saturate();
    test_frame_latch();
    test_priority_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
